// File: rtl/aes_block_packer.sv
// Packs four 32-bit stream words into one 128-bit AES block, double-buffered, under a job-level block counter.
// Optional macro AES_PACKER_STRB_CHECK_EN enables the sticky strobe error on err_o.
module aes_block_packer #(
    parameter int unsigned MSB_FIRST = 0,
    parameter int unsigned CNT_W     = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clear_i,
    input  logic               start_i,
    input  logic [CNT_W-1:0]   n_blocks_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [31:0]        in_data_i,
    input  logic [3:0]         in_strb_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [127:0]       out_data_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   n_q;
    logic [CNT_W-1:0]   in_blk_q, in_blk_d;
    logic [CNT_W-1:0]   out_blk_q, out_blk_d;
    logic [1:0]         widx_q, widx_d;
    logic [127:0]       acc_q, acc_d;
    logic               acc_full_q, acc_full_d;
    logic [127:0]       out_q, out_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, done_q;
    logic               err_q, err_d;

    logic               in_ready;
    logic               in_hs;
    logic               out_hs;
    logic               out_free;
    logic               last_word;
    logic               start_ok;
    logic [127:0]       packed_w;

    function automatic logic [127:0] put_word(input logic [127:0] blk,
                                              input logic [1:0]   idx,
                                              input logic [31:0]  w);
        logic [127:0] r;
        int unsigned  pos;
        r = blk;
        if (MSB_FIRST != 0) pos = 32'd3 - {30'd0, idx};
        else                pos = {30'd0, idx};
        r[32*pos +: 32] = w;
        return r;
    endfunction

    always_comb begin
        in_ready  = (state_q == ST_RUN) & ~acc_full_q & (in_blk_q < n_q);
        in_hs     = in_valid_i & in_ready;
        out_hs    = out_valid_q & out_ready_i;
        out_free  = ~out_valid_q | out_ready_i;
        last_word = in_hs & (widx_q == 2'd3);
        start_ok  = (state_q == ST_IDLE) & start_i;
        packed_w  = put_word(acc_q, widx_q, in_data_i);
    end

    always_comb begin
        acc_d       = in_hs ? packed_w : acc_q;
        widx_d      = in_hs ? widx_q + 2'd1 : widx_q;
        in_blk_d    = last_word ? in_blk_q + 1'b1 : in_blk_q;
        out_blk_d   = (out_hs && (out_blk_q != n_q)) ? out_blk_q + 1'b1 : out_blk_q;
        acc_full_d  = acc_full_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;

        // A completing word bypasses straight into a free output register, so
        // acc_full only marks a finished block stalled behind the output.
        if (acc_full_q && out_free) begin
            out_d       = acc_q;
            out_valid_d = 1'b1;
            acc_full_d  = 1'b0;
        end else if (last_word && out_free) begin
            out_d       = packed_w;
            out_valid_d = 1'b1;
        end else begin
            if (last_word) acc_full_d = 1'b1;
            if (out_hs)    out_valid_d = 1'b0;
        end

        if (start_ok) begin
            widx_d     = '0;
            in_blk_d   = '0;
            out_blk_d  = '0;
            acc_full_d = 1'b0;
        end
    end

`ifdef AES_PACKER_STRB_CHECK_EN
    always_comb begin
        err_d = err_q;
        if (start_ok)                           err_d = 1'b0;
        else if (in_hs && (in_strb_i != 4'hF))  err_d = 1'b1;
    end
`else
    logic unused_strb;
    assign unused_strb = ^in_strb_i;
    assign err_d       = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            n_q         <= '0;
            in_blk_q    <= '0;
            out_blk_q   <= '0;
            widx_q      <= '0;
            acc_q       <= '0;
            acc_full_q  <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else if (clear_i) begin
            state_q     <= ST_IDLE;
            n_q         <= '0;
            in_blk_q    <= '0;
            out_blk_q   <= '0;
            widx_q      <= '0;
            acc_q       <= '0;
            acc_full_q  <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            in_blk_q    <= in_blk_d;
            out_blk_q   <= out_blk_d;
            widx_q      <= widx_d;
            acc_q       <= acc_d;
            acc_full_q  <= acc_full_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;

            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        n_q <= n_blocks_i;
                        if (n_blocks_i == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= ST_RUN;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (out_hs && (out_blk_d == n_q)) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_aes_block_packer.sv
// Bench for aes_block_packer: three instances (LSB-first, MSB-first, 3-bit counter) share one stimulus
// and are checked every cycle against a word-queue model of the job.
module tb_aes_block_packer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clear;
    logic         start;
    logic [15:0]  n_blocks;
    logic         in_valid;
    logic [31:0]  in_data;
    logic [3:0]   in_strb;
    logic         out_ready;

    logic         in_ready_w  [3];
    logic         out_valid_w [3];
    logic [127:0] out_data_w  [3];
    logic         busy_w      [3];
    logic         done_w      [3];
    logic         err_w       [3];

    int n_assert = 0;
    int n_fail   = 0;

    // job model
    int          phase = 0;      // 0 idle, 1 run, 2 done
    int          job_n = 0;
    int          words = 0;
    int          blocks = 0;
    bit          err_exp = 1'b0;
    logic [31:0] mq[$];
    int          obs_words = 0;
    int          obs_done  = 0;

    always #5 clk = ~clk;

    aes_block_packer #(.MSB_FIRST(0), .CNT_W(16)) dut_lsb (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .start_i(start), .n_blocks_i(n_blocks),
        .in_valid_i(in_valid), .in_ready_o(in_ready_w[0]), .in_data_i(in_data), .in_strb_i(in_strb),
        .out_valid_o(out_valid_w[0]), .out_ready_i(out_ready), .out_data_o(out_data_w[0]),
        .busy_o(busy_w[0]), .done_o(done_w[0]), .err_o(err_w[0]));

    aes_block_packer #(.MSB_FIRST(1), .CNT_W(16)) dut_msb (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .start_i(start), .n_blocks_i(n_blocks),
        .in_valid_i(in_valid), .in_ready_o(in_ready_w[1]), .in_data_i(in_data), .in_strb_i(in_strb),
        .out_valid_o(out_valid_w[1]), .out_ready_i(out_ready), .out_data_o(out_data_w[1]),
        .busy_o(busy_w[1]), .done_o(done_w[1]), .err_o(err_w[1]));

    aes_block_packer #(.MSB_FIRST(0), .CNT_W(3)) dut_c3 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .start_i(start), .n_blocks_i(n_blocks[2:0]),
        .in_valid_i(in_valid), .in_ready_o(in_ready_w[2]), .in_data_i(in_data), .in_strb_i(in_strb),
        .out_valid_o(out_valid_w[2]), .out_ready_i(out_ready), .out_data_o(out_data_w[2]),
        .busy_o(busy_w[2]), .done_o(done_w[2]), .err_o(err_w[2]));

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: check all instances against the model at the negedge, then advance the model.
    task automatic cycle();
        int          q;
        bit          exp_ov, exp_ir, ihs, ohs;
        logic [127:0] ed;
        @(negedge clk);
        q      = mq.size();
        exp_ov = (q >= 4);
        exp_ir = (phase == 1) && (words < 4 * job_n) && (q < 8);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("in_ready[%0d]", i),  in_ready_w[i],  exp_ir);
            chk($sformatf("out_valid[%0d]", i), out_valid_w[i], exp_ov);
            chk($sformatf("busy[%0d]", i),      busy_w[i],      phase == 1);
            chk($sformatf("done[%0d]", i),      done_w[i],      phase == 2);
            chk($sformatf("err[%0d]", i),       err_w[i],       err_exp);
            if (exp_ov) begin
                if (i == 1) ed = {mq[0], mq[1], mq[2], mq[3]};
                else        ed = {mq[3], mq[2], mq[1], mq[0]};
                chk($sformatf("out_data[%0d]", i), out_data_w[i], ed);
            end
        end
        obs_words += int'(in_valid & in_ready_w[0]);
        obs_done  += int'(done_w[0]);
        ihs = in_valid & exp_ir;
        ohs = out_ready & exp_ov;
        if (clear) begin
            phase = 0; mq.delete(); words = 0; blocks = 0; err_exp = 1'b0;
        end else begin
            case (phase)
                0: if (start) begin
                    job_n = int'(n_blocks); words = 0; blocks = 0; err_exp = 1'b0;
                    phase = (n_blocks == 16'd0) ? 2 : 1;
                end
                1: begin
                    if (ohs) begin
                        repeat (4) void'(mq.pop_front());
                        blocks++;
                        if (blocks == job_n) phase = 2;
                    end
                    if (ihs) begin
                        mq.push_back(in_data);
                        words++;
`ifdef AES_PACKER_STRB_CHECK_EN
                        if (in_strb != 4'hF) err_exp = 1'b1;
`endif
                    end
                end
                default: phase = 0;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int n);
        start     = 1'b1;
        n_blocks  = n[15:0];
        obs_words = 0;
        obs_done  = 0;
        cycle();
        start     = 1'b0;
    endtask

    task automatic wait_job(input bit rnd, input int bound);
        int k;
        k = 0;
        while (phase != 0 && k < bound) begin
            in_data = $urandom;
            if (rnd) begin
                in_valid  = ($urandom_range(0, 9) < 7);
                out_ready = ($urandom_range(0, 9) < 6);
                in_strb   = ($urandom_range(0, 15) == 0) ? 4'h7 : 4'hF;
            end
            cycle();
            k++;
        end
        chk("job_timeout", phase, 0);
        in_strb = 4'hF;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] bw[4];
        int          n;
        bw[0] = 32'h00112233; bw[1] = 32'h44556677; bw[2] = 32'h8899AABB; bw[3] = 32'hCCDDEEFF;

        rst_n = 1'b0; clear = 1'b0; start = 1'b0; n_blocks = '0;
        in_valid = 1'b0; in_data = '0; in_strb = 4'hF; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_in_ready",  in_ready_w[i],  0);
            chk("rst_out_valid", out_valid_w[i], 0);
            chk("rst_out_data",  out_data_w[i],  0);
            chk("rst_busy",      busy_w[i],      0);
            chk("rst_done",      done_w[i],      0);
            chk("rst_err",       err_w[i],       0);
        end
        rst_n = 1'b1;
        cycle();

        // basic packing, both word orders
        start_job(1);
        chk("basic_busy", busy_w[0], 1);
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = bw[i];
            cycle();
        end
        in_valid = 1'b0;
        chk("basic_valid", out_valid_w[0], 1);
        chk("basic_lsb", out_data_w[0], 128'hCCDDEEFF_8899AABB_44556677_00112233);
        chk("basic_msb", out_data_w[1], 128'h00112233_44556677_8899AABB_CCDDEEFF);
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        chk("basic_done", done_w[0], 1);
        chk("basic_busy_fall", busy_w[0], 0);
        cycle();
        chk("basic_done_pulse", done_w[0], 0);

        // backpressure
        start_job(3);
        in_valid = 1'b1;
        repeat (12) begin
            in_data = $urandom;
            cycle();
        end
        chk("bp_words_stalled", obs_words, 8);
        chk("bp_in_ready", in_ready_w[0], 0);
        out_ready = 1'b1;
        wait_job(1'b0, 60);
        chk("bp_words_total", obs_words, 12);
        chk("bp_done_cnt", obs_done, 1);

        // throughput and job bound
        start_job(4);
        repeat (16) begin
            in_data = $urandom;
            cycle();
        end
        chk("tp_words", obs_words, 16);
        wait_job(1'b0, 20);
        repeat (3) cycle();
        chk("tp_words_bound", obs_words, 16);
        chk("tp_in_ready", in_ready_w[0], 0);
        chk("tp_done_cnt", obs_done, 1);
        in_valid = 1'b0;
        out_ready = 1'b0;

        // zero-length job
        in_valid = 1'b1;
        start_job(0);
        chk("zero_done", done_w[0], 1);
        chk("zero_in_ready", in_ready_w[0], 0);
        cycle();
        chk("zero_done_pulse", done_w[0], 0);
        chk("zero_words", obs_words, 0);
        in_valid = 1'b0;

        // clear mid-job, then a fresh job
        start_job(2);
        in_valid = 1'b1;
        repeat (2) begin
            in_data = $urandom;
            cycle();
        end
        in_valid = 1'b0;
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        chk("clr_busy", busy_w[0], 0);
        chk("clr_in_ready", in_ready_w[0], 0);
        start_job(1);
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = bw[i];
            cycle();
        end
        in_valid = 1'b0;
        chk("clr_fresh_lsb", out_data_w[0], 128'hCCDDEEFF_8899AABB_44556677_00112233);
        out_ready = 1'b1;
        wait_job(1'b0, 10);
        out_ready = 1'b0;

`ifdef AES_PACKER_STRB_CHECK_EN
        start_job(1);
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = bw[i];
            in_strb = (i == 2) ? 4'h7 : 4'hF;
            cycle();
            if (i == 2) chk("strb_err_set", err_w[0], 1);
        end
        in_valid = 1'b0;
        in_strb  = 4'hF;
        chk("strb_block", out_data_w[0], 128'hCCDDEEFF_8899AABB_44556677_00112233);
        out_ready = 1'b1;
        wait_job(1'b0, 10);
        chk("strb_err_sticky", err_w[0], 1);
        start_job(1);
        chk("strb_err_cleared", err_w[0], 0);
        wait_job(1'b1, 200);
`endif

        // largest job the 3-bit counter can hold
        start_job(7);
        wait_job(1'b1, 600);
        chk("max_words", obs_words, 28);
        chk("max_done_cnt", obs_done, 1);

        // random jobs
        repeat (6) begin
            n = $urandom_range(1, 6);
            start_job(n);
            wait_job(1'b1, 500);
            chk("rnd_words", obs_words, 4 * n);
            chk("rnd_done_cnt", obs_done, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
